// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared definitions for the multi-channel PWM generator:
//               register address map and counting-mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Register map seen on the write port
  localparam int PWM_A_CTRL     = 0;  // [1] mode, [0] enable
  localparam int PWM_A_PRESCALE = 1;
  localparam int PWM_A_PERIOD   = 2;
  localparam int PWM_A_CH_EN    = 3;
  localparam int PWM_A_POL      = 4;
  localparam int PWM_A_DUTY0    = 8;  // DUTY[i] lives at PWM_A_DUTY0 + i

  // Counting mode of the shared period counter
  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTRE = 1'b1
  } pwm_mode_e;

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase
// Description : Shared prescaler and up / up-down period counter with
//               period-boundary detection for the PWM channels.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  pwm_mode_e          i_mode,
  input  logic [PRESC_W-1:0] i_prescale,
  input  logic [CNT_W-1:0]   i_period,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_boundary
);

  logic [PRESC_W-1:0] r_presc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dir_down;
  logic               w_tick;
  logic               w_boundary;

  assign w_tick = i_en && (r_presc == i_prescale);

  // Boundary: top of the ramp in edge mode, bottom of the valley on the way
  // down in centre mode (every tick when a centre period of zero pins cnt at 0)
  always_comb begin
    w_boundary = 1'b0;
    if (w_tick) begin
      if (i_mode == PWM_EDGE) begin
        w_boundary = (r_cnt == i_period);
      end else begin
        w_boundary = (r_cnt == '0) && (r_dir_down || (i_period == '0));
      end
    end
  end

  // Prescaler and counter; both parked at zero, direction up, while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_cnt      <= '0;
      r_dir_down <= 1'b0;
    end else if (!i_en) begin
      r_presc    <= '0;
      r_cnt      <= '0;
      r_dir_down <= 1'b0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (i_mode == PWM_EDGE) begin
        // Explicit wrap compare so an all-ones period never relies on carry
        r_dir_down <= 1'b0;
        r_cnt      <= (r_cnt >= i_period) ? '0 : r_cnt + CNT_W'(1);
      end else if (i_period == '0) begin
        r_dir_down <= 1'b0;
        r_cnt      <= '0;
      end else if (!r_dir_down) begin
        // '>=' turns around safely if a new, shorter period arrives at cnt=1
        if (r_cnt >= i_period) begin
          r_dir_down <= 1'b1;
          r_cnt      <= r_cnt - CNT_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        if (r_cnt == '0) begin
          r_dir_down <= 1'b0;
          r_cnt      <= CNT_W'(1);
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  assign o_cnt      = r_cnt;
  assign o_boundary = w_boundary;

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi
// Description : Multi-channel PWM generator. Register file with shadow and
//               active copies, shared timebase, NUM_CH compare channels with
//               per-channel enable, polarity and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 16,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  output logic [NUM_CH-1:0] o_pwm_out,
  output logic              o_period_tick,
  output logic [CNT_W-1:0]  o_cnt_out
);

  // Direct (unshadowed) controls
  logic               r_en;
  logic [NUM_CH-1:0]  r_ch_en;
  logic [NUM_CH-1:0]  r_pol;

  // Shadow copies written by software
  pwm_mode_e          r_mode_sh;
  logic [PRESC_W-1:0] r_presc_sh;
  logic [CNT_W-1:0]   r_period_sh;

  // Active copies used by the timebase
  pwm_mode_e          r_mode_act;
  logic [PRESC_W-1:0] r_presc_act;
  logic [CNT_W-1:0]   r_period_act;

  logic               r_period_tick;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_boundary;
  logic               w_load_act;
  logic               w_wr_ctrl;
  logic               w_wr_presc;
  logic               w_wr_period;
  logic               w_wr_ch_en;
  logic               w_wr_pol;
  logic               w_unused_data;

  assign w_wr_ctrl   = i_wr_en && (i_wr_addr == ADDR_W'(PWM_A_CTRL));
  assign w_wr_presc  = i_wr_en && (i_wr_addr == ADDR_W'(PWM_A_PRESCALE));
  assign w_wr_period = i_wr_en && (i_wr_addr == ADDR_W'(PWM_A_PERIOD));
  assign w_wr_ch_en  = i_wr_en && (i_wr_addr == ADDR_W'(PWM_A_CH_EN));
  assign w_wr_pol    = i_wr_en && (i_wr_addr == ADDR_W'(PWM_A_POL));

  // Upper write-data bits are don't-care for every register
  assign w_unused_data = ^i_wr_data;

  // Active registers follow the shadows freely while idle, else only at a
  // boundary; a same-cycle write lands in the shadow after this copy.
  assign w_load_act = !r_en || w_boundary;

  // Software-visible register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en        <= 1'b0;
      r_mode_sh   <= PWM_EDGE;
      r_presc_sh  <= '0;
      r_period_sh <= '0;
      r_ch_en     <= '0;
      r_pol       <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en      <= i_wr_data[0];
        r_mode_sh <= pwm_mode_e'(i_wr_data[1]);
      end
      if (w_wr_presc)  r_presc_sh  <= i_wr_data[PRESC_W-1:0];
      if (w_wr_period) r_period_sh <= i_wr_data[CNT_W-1:0];
      if (w_wr_ch_en)  r_ch_en     <= i_wr_data[NUM_CH-1:0];
      if (w_wr_pol)    r_pol       <= i_wr_data[NUM_CH-1:0];
    end
  end

  // Shadow-to-active transfer of the timebase settings
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_act   <= PWM_EDGE;
      r_presc_act  <= '0;
      r_period_act <= '0;
    end else if (w_load_act) begin
      r_mode_act   <= r_mode_sh;
      r_presc_act  <= r_presc_sh;
      r_period_act <= r_period_sh;
    end
  end

  // One-clock period marker following each boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_tick <= 1'b0;
    end else begin
      r_period_tick <= w_boundary;
    end
  end

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (r_en),
    .i_mode     (r_mode_act),
    .i_prescale (r_presc_act),
    .i_period   (r_period_act),
    .o_cnt      (w_cnt),
    .o_boundary (w_boundary)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_duty_sh;
    logic [CNT_W-1:0] r_duty_act;
    logic             r_out;
    logic             w_wr_duty;
    logic             w_raw;

    assign w_wr_duty = i_wr_en && (i_wr_addr == ADDR_W'(PWM_A_DUTY0 + i));

    // Duty shadow register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_duty_sh <= '0;
      end else if (w_wr_duty) begin
        r_duty_sh <= i_wr_data[CNT_W-1:0];
      end
    end

    // Duty active register, updated alongside the timebase settings
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_duty_act <= '0;
      end else if (w_load_act) begin
        r_duty_act <= r_duty_sh;
      end
    end

    // Active while the count is below the duty; both modes share the compare,
    // which makes the centre-mode pulse symmetric about the valley.
    assign w_raw = r_en && r_ch_en[i] && (w_cnt < r_duty_act);

    // Registered output with polarity applied
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out <= 1'b0;
      end else begin
        r_out <= w_raw ^ r_pol[i];
      end
    end

    assign o_pwm_out[i] = r_out;
  end

  assign o_period_tick = r_period_tick;
  assign o_cnt_out     = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi
// Description : Directed self-checking bench for pwm_multi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

  localparam logic [4:0] A_CTRL   = 5'd0;
  localparam logic [4:0] A_PRESC  = 5'd1;
  localparam logic [4:0] A_PERIOD = 5'd2;
  localparam logic [4:0] A_CH_EN  = 5'd3;
  localparam logic [4:0] A_POL    = 5'd4;
  localparam logic [4:0] A_DUTY0  = 5'd8;
  localparam logic [4:0] A_DUTY1  = 5'd9;
  localparam logic [4:0] A_DUTY2  = 5'd10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  pwm;
  logic        tick;
  logic [15:0] cnt;

  int n_cmp = 0;
  int n_err = 0;

  pwm_multi #(
    .NUM_CH  (4),
    .CNT_W   (16),
    .PRESC_W (16),
    .ADDR_W  (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (wr_en),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .o_pwm_out     (pwm),
    .o_period_tick (tick),
    .o_cnt_out     (cnt)
  );

  always #5 clk = ~clk;

  // One register write; returns at the negedge just after the capturing edge
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pwm !== 4'h0) begin n_err++; $display("FAIL rst_pwm got %h exp 0", pwm); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL rst_tick got %b exp 0", tick); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", cnt); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (pwm !== 4'h0) begin n_err++; $display("FAIL idle_pwm got %h exp 0", pwm); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL idle_cnt got %0d exp 0", cnt); end
  endtask

  task automatic test_edge();
    logic [15:0] e_cnt;
    logic [3:0]  e_pwm;
    logic        e_tick;
    wr(A_PERIOD, 32'd9); wr(A_DUTY0, 32'd3); wr(A_CH_EN, 32'd1); wr(A_CTRL, 32'd1);
    for (int k = 0; k < 30; k++) begin
      e_cnt  = 16'(k % 10);
      e_pwm  = (k >= 1 && ((k - 1) % 10) < 3) ? 4'h1 : 4'h0;
      e_tick = (k >= 1 && ((k - 1) % 10) == 9);
      n_cmp++; if (cnt !== e_cnt) begin n_err++; $display("FAIL edge_cnt k=%0d got %0d exp %0d", k, cnt, e_cnt); end
      n_cmp++; if (pwm !== e_pwm) begin n_err++; $display("FAIL edge_pwm k=%0d got %h exp %h", k, pwm, e_pwm); end
      n_cmp++; if (tick !== e_tick) begin n_err++; $display("FAIL edge_tick k=%0d got %b exp %b", k, tick, e_tick); end
      @(negedge clk);
    end
  endtask

  task automatic test_centre();
    int          m, c, cp;
    logic [3:0]  e_pwm;
    logic        e_tick;
    wr(A_CTRL, 32'd0); wr(A_CTRL, 32'd2); wr(A_PERIOD, 32'd4); wr(A_DUTY0, 32'd2);
    wr(A_CTRL, 32'd3);
    for (int k = 0; k < 25; k++) begin
      m  = k % 8;
      c  = (m <= 4) ? m : 8 - m;
      m  = (k + 7) % 8;
      cp = (m <= 4) ? m : 8 - m;
      e_pwm  = (k >= 1 && cp < 2) ? 4'h1 : 4'h0;
      e_tick = (k >= 2 && ((k - 1) % 8) == 0);
      n_cmp++; if (cnt !== 16'(c)) begin n_err++; $display("FAIL ctr_cnt k=%0d got %0d exp %0d", k, cnt, c); end
      n_cmp++; if (pwm !== e_pwm) begin n_err++; $display("FAIL ctr_pwm k=%0d got %h exp %h", k, pwm, e_pwm); end
      n_cmp++; if (tick !== e_tick) begin n_err++; $display("FAIL ctr_tick k=%0d got %b exp %b", k, tick, e_tick); end
      @(negedge clk);
    end
  endtask

  task automatic test_shadow();
    int         j, d;
    logic [3:0] e_pwm;
    wr(A_CTRL, 32'd0); wr(A_PERIOD, 32'd9); wr(A_DUTY0, 32'd3); wr(A_CTRL, 32'd1);
    for (int k = 0; k < 40; k++) begin
      j = k - 1;
      d = (j <= 9) ? 3 : (j <= 29) ? 6 : 2;
      e_pwm = (k >= 1 && (j % 10) < d) ? 4'h1 : 4'h0;
      n_cmp++; if (pwm !== e_pwm) begin n_err++; $display("FAIL shadow_pwm k=%0d got %h exp %h", k, pwm, e_pwm); end
      wr_en = 1'b0;
      if (k == 4)  begin wr_en = 1'b1; wr_addr = A_DUTY0; wr_data = 32'd6; end
      if (k == 19) begin wr_en = 1'b1; wr_addr = A_DUTY0; wr_data = 32'd2; end
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_limits();
    int         j;
    logic [3:0] e_pwm;
    wr(A_CTRL, 32'd0); wr(A_DUTY0, 32'd0); wr(A_DUTY1, 32'd10); wr(A_DUTY2, 32'd3);
    wr(A_CH_EN, 32'h7); wr(A_POL, 32'hC); wr(A_CTRL, 32'd1);
    for (int k = 0; k < 25; k++) begin
      j = k - 1;
      if (k == 0) e_pwm = 4'hC;
      else        e_pwm = {1'b1, ((j % 10) < 3) ? 1'b0 : 1'b1, 1'b1, 1'b0};
      n_cmp++; if (pwm !== e_pwm) begin n_err++; $display("FAIL limit_pwm k=%0d got %h exp %h", k, pwm, e_pwm); end
      wr_en = 1'b0;
      // Address 12 would be DUTY[4], which does not exist with four channels
      if (k == 3) begin wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'd5; end
      if (k == 4) begin wr_en = 1'b1; wr_addr = 5'd5;  wr_data = 32'hFFFF; end
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_prescale();
    logic [15:0] e_cnt;
    logic [3:0]  e_pwm;
    logic        e_tick;
    wr(A_CTRL, 32'd0); wr(A_CH_EN, 32'h1); wr(A_POL, 32'h0); wr(A_DUTY0, 32'd3);
    wr(A_PRESC, 32'd2); wr(A_CTRL, 32'd1);
    for (int k = 0; k < 62; k++) begin
      e_cnt  = 16'((k / 3) % 10);
      e_pwm  = (k >= 1 && (((k - 1) / 3) % 10) < 3) ? 4'h1 : 4'h0;
      e_tick = (k > 0 && (k % 30) == 0);
      n_cmp++; if (cnt !== e_cnt) begin n_err++; $display("FAIL psc_cnt k=%0d got %0d exp %0d", k, cnt, e_cnt); end
      n_cmp++; if (pwm !== e_pwm) begin n_err++; $display("FAIL psc_pwm k=%0d got %h exp %h", k, pwm, e_pwm); end
      n_cmp++; if (tick !== e_tick) begin n_err++; $display("FAIL psc_tick k=%0d got %b exp %b", k, tick, e_tick); end
      @(negedge clk);
    end
    wr(A_CTRL, 32'd0); wr(A_POL, 32'hA);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL dis_cnt k=%0d got %0d exp 0", k, cnt); end
      n_cmp++; if (pwm !== 4'hA) begin n_err++; $display("FAIL dis_pwm k=%0d got %h exp a", k, pwm); end
      n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL dis_tick k=%0d got %b exp 0", k, tick); end
    end
  endtask

  task automatic test_async_reset();
    wr(A_POL, 32'hF); wr(A_CH_EN, 32'h0); wr(A_CTRL, 32'd1);
    repeat (4) @(negedge clk);
    n_cmp++; if (pwm !== 4'hF) begin n_err++; $display("FAIL pre_rst_pwm got %h exp f", pwm); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (pwm !== 4'h0) begin n_err++; $display("FAIL arst_pwm got %h exp 0", pwm); end
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL arst_tick got %b exp 0", tick); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL arst_cnt got %0d exp 0", cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (pwm !== 4'h0) begin n_err++; $display("FAIL post_rst_pwm got %h exp 0", pwm); end
    n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL post_rst_cnt got %0d exp 0", cnt); end
    // Only the enable is set: zeroed PERIOD/PRESCALE give a boundary every clock
    wr(A_CTRL, 32'd1);
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL zero_cnt k=%0d got %0d exp 0", k, cnt); end
      n_cmp++; if (pwm !== 4'h0) begin n_err++; $display("FAIL zero_pwm k=%0d got %h exp 0", k, pwm); end
      n_cmp++; if (tick !== (k >= 1)) begin n_err++; $display("FAIL zero_tick k=%0d got %b exp %b", k, tick, (k >= 1)); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_centre();
    test_shadow();
    test_limits();
    test_prescale();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
